// File: rtl/rv_pkg.sv
// Shared constants and types for the R-type fetch/decode stage and its ALU.
package rv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALU_W   = 4;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;
  localparam logic [INSTR_W-1:0] ECALL_WORD = 32'h0000_0073;

  // ALU operation codes, shared with the ALU
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [ALU_W-1:0] alu_control;
    logic             legal;
  } decode_t;

endpackage

// File: rtl/rv_fetch_decode_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface rv_fetch_decode_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/rv_rtype_decoder.sv
// Combinational RV32I R-type decoder: register fields, ALU code and legality.
module rv_rtype_decoder
  import rv_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output decode_t            dec_c
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Anything not recognised decodes to ADD with legal cleared
  always_comb begin
    dec_c.rs1         = instr[19:15];
    dec_c.rs2         = instr[24:20];
    dec_c.rd          = instr[11:7];
    dec_c.alu_control = ALU_ADD;
    dec_c.legal       = 1'b0;
    if (opcode == OPCODE_RTYPE) begin
      if (funct7 == FUNCT7_BASE) begin
        dec_c.legal = 1'b1;
        case (funct3)
          3'b000:  dec_c.alu_control = ALU_ADD;
          3'b001:  dec_c.alu_control = ALU_SLL;
          3'b010:  dec_c.alu_control = ALU_SLT;
          3'b011:  dec_c.alu_control = ALU_SLTU;
          3'b100:  dec_c.alu_control = ALU_XOR;
          3'b101:  dec_c.alu_control = ALU_SRL;
          3'b110:  dec_c.alu_control = ALU_OR;
          3'b111:  dec_c.alu_control = ALU_AND;
          default: dec_c.alu_control = ALU_ADD;
        endcase
      end else if (funct7 == FUNCT7_ALT) begin
        case (funct3)
          3'b000: begin
            dec_c.alu_control = ALU_SUB;
            dec_c.legal       = 1'b1;
          end
          3'b101: begin
            dec_c.alu_control = ALU_SRA;
            dec_c.legal       = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/rv_fetch_decode.sv
// Multi-cycle fetch/decode control stage: one instruction in flight, drives the
// R-type datapath register numbers, ALU code and register-file write strobe.
module rv_fetch_decode
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  rv_fetch_decode_if.master   imem,
  output logic [REG_W-1:0]    read_reg_num1,
  output logic [REG_W-1:0]    read_reg_num2,
  output logic [REG_W-1:0]    write_reg,
  output logic [ALU_W-1:0]    alu_control,
  output logic                regwrite,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic [CNT_W-1:0]    illegal_count
);

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 halted_q, halted_d;
  logic                 req_q, req_d;
  logic                 regwrite_q, regwrite_d;
  decode_t              dec_c;

  rv_rtype_decoder u_dec (
    .instr (instr_q),
    .dec_c (dec_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_RST;
      instr_q    <= '0;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      req_q      <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      req_q      <= req_d;
      regwrite_q <= regwrite_d;
    end
  end

  // Next state; req/regwrite are registered from the state being entered
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !halted_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (instr_q == ECALL_WORD) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d = pc_q + PC_STEP;
        if (!dec_c.legal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
    req_d      = (state_d == ST_FETCH);
    regwrite_d = (state_d == ST_EXEC) && dec_c.legal && (dec_c.rd != '0);
  end

  assign imem.req      = req_q;
  assign imem.addr     = pc_q;
  assign read_reg_num1 = dec_c.rs1;
  assign read_reg_num2 = dec_c.rs2;
  assign write_reg     = dec_c.rd;
  assign alu_control   = dec_c.alu_control;
  assign regwrite      = regwrite_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_rv_fetch_decode.sv
// Self-checking bench for rv_fetch_decode: directed and random instructions against a reference model.
module tb_rv_fetch_decode;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        we;
    logic [31:0] pc;
    logic        halted;
    logic [7:0]  cnt;
  } obs_t;

  logic clock = 1'b0;
  logic reset;
  logic enable0, enable1;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] mpc [2];
  int          mcnt [2];
  int          cmax [2];

  always #5 clock = ~clock;

  rv_fetch_decode_if #(.ADDR_W(32)) a_if ();
  rv_fetch_decode_if #(.ADDR_W(32)) b_if ();

  logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  logic [3:0]  a_alu, b_alu;
  logic        a_we, b_we, a_halted, b_halted;
  logic [31:0] a_pc, b_pc;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  rv_fetch_decode #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .CNT_W(8)) u_a (
    .clock(clock), .reset(reset), .enable(enable0), .imem(a_if.master),
    .read_reg_num1(a_rs1), .read_reg_num2(a_rs2), .write_reg(a_rd),
    .alu_control(a_alu), .regwrite(a_we), .pc(a_pc), .halted(a_halted),
    .illegal_count(a_cnt)
  );

  rv_fetch_decode #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .enable(enable1), .imem(b_if.master),
    .read_reg_num1(b_rs1), .read_reg_num2(b_rs2), .write_reg(b_rd),
    .alu_control(b_alu), .regwrite(b_we), .pc(b_pc), .halted(b_halted),
    .illegal_count(b_cnt)
  );

  function automatic obs_t get(input int k);
    obs_t o;
    if (k == 0) begin
      o.req = a_if.req; o.addr = a_if.addr; o.rs1 = a_rs1; o.rs2 = a_rs2; o.rd = a_rd;
      o.alu = a_alu; o.we = a_we; o.pc = a_pc; o.halted = a_halted; o.cnt = a_cnt;
    end else begin
      o.req = b_if.req; o.addr = b_if.addr; o.rs1 = b_rs1; o.rs2 = b_rs2; o.rd = b_rd;
      o.alu = b_alu; o.we = b_we; o.pc = b_pc; o.halted = b_halted; o.cnt = 8'(b_cnt);
    end
    return o;
  endfunction

  task automatic drive(input int k, input logic ack, input logic [31:0] data);
    if (k == 0) begin
      a_if.ack = ack; a_if.rdata = data;
    end else begin
      b_if.ack = ack; b_if.rdata = data;
    end
  endtask

  task automatic set_en(input int k, input logic v);
    if (k == 0) enable0 = v;
    else        enable1 = v;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference decode straight from the instruction-set table
  function automatic void ref_dec(input logic [31:0] w, output logic legal, output logic [3:0] alu);
    logic [3:0] base_tbl [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    base_tbl = '{4'h2, 4'h8, 4'h7, 4'hB, 4'h4, 4'h9, 4'h1, 4'h0};
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    legal = (op == 7'h33) && ((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
    alu = (f7 == 7'h00) ? base_tbl[f3] : ((f3 == 3'd0) ? 4'h6 : 4'hA);
  endfunction

  task automatic run_instr(input int k, input logic [31:0] word, input int delay, input logic drop_en);
    obs_t       o;
    logic       legal, we_exp, is_ecall;
    logic [3:0] alu;
    int         n;
    ref_dec(word, legal, alu);
    is_ecall = (word == 32'h0000_0073);
    we_exp   = legal && (word[11:7] != 5'd0);
    n = 0;
    o = get(k);
    while (o.req !== 1'b1 && n < 40) begin
      @(negedge clock);
      o = get(k);
      n++;
    end
    check("req_assert", 32'(o.req), 32'd1);
    for (int i = 0; i < delay; i++) begin
      check("req_hold", 32'(o.req), 32'd1);
      check("addr_hold", o.addr, mpc[k]);
      drive(k, 1'b0, $urandom);
      @(negedge clock);
      o = get(k);
    end
    check("addr_fetch", o.addr, mpc[k]);
    check("pc_fetch", o.pc, mpc[k]);
    drive(k, 1'b1, word);
    @(negedge clock);
    // Stray acks outside FETCH must be ignored
    drive(k, 1'($urandom_range(0, 1)), $urandom);
    if (drop_en) set_en(k, 1'b0);
    o = get(k);
    check("req_drop", 32'(o.req), 32'd0);
    check("we_decode", 32'(o.we), 32'd0);
    check("rs1", 32'(o.rs1), 32'(word[19:15]));
    check("rs2", 32'(o.rs2), 32'(word[24:20]));
    check("rd", 32'(o.rd), 32'(word[11:7]));
    if (legal) check("alu_control", 32'(o.alu), 32'(alu));
    if (is_ecall) begin
      drive(k, 1'b0, 32'd0);
      @(negedge clock);
      o = get(k);
      check("halted_set", 32'(o.halted), 32'd1);
      check("we_ecall", 32'(o.we), 32'd0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        o = get(k);
        check("halt_req", 32'(o.req), 32'd0);
        check("halt_pc", o.pc, mpc[k]);
      end
      return;
    end
    @(negedge clock);
    o = get(k);
    check("regwrite_exec", 32'(o.we), 32'(we_exp));
    check("pc_exec", o.pc, mpc[k]);
    check("rd_stable", 32'(o.rd), 32'(word[11:7]));
    drive(k, 1'($urandom_range(0, 1)), $urandom);
    @(negedge clock);
    drive(k, 1'b0, 32'd0);
    o = get(k);
    mpc[k] = mpc[k] + 32'd4;
    if (!legal && mcnt[k] < cmax[k]) mcnt[k]++;
    check("we_after", 32'(o.we), 32'd0);
    check("req_idle", 32'(o.req), 32'd0);
    check("pc_next", o.pc, mpc[k]);
    check("illegal_count", 32'(o.cnt), 32'(mcnt[k]));
    check("halted_clear", 32'(o.halted), 32'd0);
  endtask

  task automatic park_check(input int k);
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      o = get(k);
      check("park_req", 32'(o.req), 32'd0);
      check("park_pc", o.pc, mpc[k]);
    end
    set_en(k, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t        o;
    logic [31:0] word;
    logic [6:0]  f7, op;
    int          sel, n;
    logic        drop;

    reset = 1'b0; enable0 = 1'b0; enable1 = 1'b0;
    drive(0, 1'b0, 32'd0);
    drive(1, 1'b0, 32'd0);
    mpc[0] = 32'h0; mpc[1] = 32'hFFFF_FFFC;
    mcnt[0] = 0; mcnt[1] = 0;
    cmax[0] = 255; cmax[1] = 3;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      o = get(k);
      check("rst_req", 32'(o.req), 32'd0);
      check("rst_we", 32'(o.we), 32'd0);
      check("rst_pc", o.pc, mpc[k]);
      check("rst_halted", 32'(o.halted), 32'd0);
      check("rst_cnt", 32'(o.cnt), 32'd0);
      check("rst_rs1", 32'(o.rs1), 32'd0);
      check("rst_rs2", 32'(o.rs2), 32'd0);
      check("rst_rd", 32'(o.rd), 32'd0);
      check("rst_alu", 32'(o.alu), 32'h2);
    end
    reset = 1'b1;
    @(negedge clock);
    enable0 = 1'b1;
    @(negedge clock);
    o = get(0);
    check("req_after_idle", 32'(o.req), 32'd1);

    run_instr(0, 32'h0020_81B3, 0, 1'b0);
    check("add_pc", a_pc, 32'd4);
    run_instr(0, 32'h4020_81B3, 0, 1'b0);
    run_instr(0, 32'h4020_D1B3, 3, 1'b0);
    run_instr(0, 32'h0000_0013, 1, 1'b0);
    run_instr(0, 32'h2020_81B3, 0, 1'b0);
    check("cnt_two", 32'(a_cnt), 32'd2);
    run_instr(0, 32'h0020_8033, 2, 1'b1);
    park_check(0);

    for (int t = 0; t < 24; t++) begin
      sel  = int'($urandom_range(0, 5));
      f7   = (sel == 0) ? 7'($urandom) : ((sel < 3) ? 7'h20 : 7'h00);
      op   = (sel == 5) ? 7'($urandom) : 7'h33;
      word = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op};
      if (word == 32'h0000_0073) word = 32'h0000_0033;
      drop = ($urandom_range(0, 4) == 0);
      run_instr(0, word, int'($urandom_range(0, 3)), drop);
      if (drop) park_check(0);
    end

    // Asynchronous reset in the middle of a fetch
    n = 0;
    while (a_if.req !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("req_before_rst", 32'(a_if.req), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_req", 32'(a_if.req), 32'd0);
    check("rst_mid_pc", a_pc, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    mpc[0] = 32'h0; mpc[1] = 32'hFFFF_FFFC;
    mcnt[0] = 0; mcnt[1] = 0;
    run_instr(0, 32'h0020_81B3, 0, 1'b0);
    run_instr(0, 32'h0000_0073, 1, 1'b0);

    // Wrapping PC and narrow saturating counter
    enable1 = 1'b1;
    run_instr(1, 32'h0020_81B3, 0, 1'b0);
    check("pc_wrap", b_pc, 32'd0);
    for (int t = 0; t < 5; t++) begin
      word = (t[0]) ? 32'h0000_0013 : 32'h2020_81B3;
      run_instr(1, word, t % 2, 1'b0);
    end
    check("cnt_saturate", 32'(b_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
